// File: rtl/exc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : exc_sequencer_if
// Description : M-stage / CP0 side-band bundle for the exception sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface exc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic              m_valid;
    logic [31:0]       m_pc;
    logic              m_bd;
    logic [4:0]        m_exccode;
    logic              m_eret;
    logic [5:0]        hwint;
    logic [5:0]        sr_im;
    logic              sr_ie;
    logic              sr_exl;
    logic [31:0]       epc_in;

    logic              flush;
    logic              pc_sel;
    logic [31:0]       next_pc;
    logic              cp0_we_exc;
    logic [4:0]        cp0_code;
    logic [31:0]       cp0_epc;
    logic              cp0_bd;
    logic [5:0]        cp0_hwint;
    logic              exl_set;
    logic              exl_clr;
    logic              in_handler;
    logic [CNT_W-1:0]  exc_count;

    modport master (
        output m_valid, m_pc, m_bd, m_exccode, m_eret, hwint,
               sr_im, sr_ie, sr_exl, epc_in,
        input  flush, pc_sel, next_pc, cp0_we_exc, cp0_code, cp0_epc,
               cp0_bd, cp0_hwint, exl_set, exl_clr, in_handler, exc_count
    );

    modport slave (
        input  m_valid, m_pc, m_bd, m_exccode, m_eret, hwint,
               sr_im, sr_ie, sr_exl, epc_in,
        output flush, pc_sel, next_pc, cp0_we_exc, cp0_code, cp0_epc,
               cp0_bd, cp0_hwint, exl_set, exl_clr, in_handler, exc_count
    );
endinterface
`default_nettype wire

// File: rtl/exc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exc_sequencer
// Description : M-stage exception/interrupt entry and eret return sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          CNT_W        = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    exc_sequencer_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        hw_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              w_irq;
    logic              w_act;
    logic              w_sync;
    logic              w_ret;
    logic              w_int;
    logic              w_entry;
    logic              w_rec;
    logic [31:0]       w_epc;

    // Decisions are suppressed during reset so no strobe leaks out of that cycle.
    always_comb begin
        w_irq   = (|(hw_q & bus.sr_im)) & bus.sr_ie & ~bus.sr_exl & (state_q == ST_IDLE);
        w_act   = bus.m_valid & ~reset;
        w_sync  = w_act & (bus.m_exccode != 5'd0);
        w_ret   = w_act & ~w_sync & bus.m_eret;
        w_int   = w_act & ~w_sync & ~bus.m_eret & w_irq;
        w_entry = w_sync | w_int;
        w_rec   = w_entry & (state_q == ST_IDLE);
        w_epc   = {bus.m_pc[31:2], 2'b00} - (bus.m_bd ? 32'd4 : 32'd0);
    end

    always_comb begin
        state_d = state_q;
        if (w_entry) begin
            state_d = ST_HANDLER;
        end else if (w_ret) begin
            state_d = ST_IDLE;
        end else if ((state_q == ST_HANDLER) && !bus.sr_exl) begin
            state_d = ST_IDLE;
        end
        cnt_d = cnt_q;
        if (w_entry && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hw_q    <= 6'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hw_q    <= bus.hwint;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.flush      = w_entry | w_ret;
    assign bus.pc_sel     = w_entry | w_ret;
    assign bus.exl_set    = w_entry;
    assign bus.exl_clr    = w_ret;
    assign bus.next_pc    = w_entry ? HANDLER_ADDR : (w_ret ? bus.epc_in : 32'd0);

    // Nested entries leave CP0 untouched so the original EPC/Cause survive.
    assign bus.cp0_we_exc = w_rec;
    assign bus.cp0_code   = w_rec ? bus.m_exccode : 5'd0;
    assign bus.cp0_epc    = w_rec ? w_epc : 32'd0;
    assign bus.cp0_bd     = w_rec & bus.m_bd;
    assign bus.cp0_hwint  = w_rec ? hw_q : 6'd0;

    assign bus.in_handler = (state_q == ST_HANDLER);
    assign bus.exc_count  = cnt_q;

endmodule
`default_nettype wire

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/interrupt entry-and-return sequencer for the five-stage MIPS pipeline. It sits beside CP0 at the M stage and decides, each cycle, whether the instruction in M raises a synchronous exception, takes a hardware interrupt, or executes `eret`. For each of these it issues the pipeline flush, the PC redirect and the CP0 update strobes. It tracks handler residency with a small state machine and keeps a saturating count of exceptions taken for debug.

## Interface
- `HANDLER_ADDR`, 32'h0000_4180: redirect target for every exception or interrupt entry.
- `CNT_W`, 16: width of the exception-taken counter.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `m_valid` in 1: M stage holds a real instruction, not a bubble.
- `m_pc` in 32: PC of the M instruction.
- `m_bd` in 1: M instruction is in a branch/jump delay slot.
- `m_exccode` in 5: synchronous exception code of the M instruction; 0 means none.
- `m_eret` in 1: M instruction is `eret`.
- `hwint` in 6: device interrupt levels [7:2].
- `sr_im` in 6: SR.IM from CP0.
- `sr_ie` in 1: SR.IE from CP0.
- `sr_exl` in 1: SR.EXL from CP0.
- `epc_in` in 32: EPC from CP0.
- `flush` out 1: kill F/D/E/M contents this cycle.
- `pc_sel` out 1: fetch PC := `next_pc` at the next edge.
- `next_pc` out 32: redirect target.
- `cp0_we_exc` out 1: CP0 captures `cp0_code`, `cp0_epc`, `cp0_bd`, `cp0_hwint`.
- `cp0_code` out 5: ExcCode to record; 0 for an interrupt.
- `cp0_epc` out 32: EPC to record.
- `cp0_bd` out 1: BD to record.
- `cp0_hwint` out 6: interrupt-pending snapshot.
- `exl_set` out 1: set SR.EXL.
- `exl_clr` out 1: clear SR.EXL.
- `in_handler` out 1: state == HANDLER.
- `exc_count` out CNT_W: number of entries taken, saturating.

## Operation
- **Interrupt sampling.** `hw_q` registers `hwint` every cycle (1-cycle latency); reset value 0. `irq = |(hw_q & sr_im) & sr_ie & ~sr_exl & (state == IDLE)`.
- **Decision.** Decisions are made combinationally in the current cycle, only when `m_valid` = 1. Priority, highest first:
  - `m_exccode != 0`: sync exception.
  - `m_eret`: return.
  - `irq`: interrupt.
  - An `eret` carrying a nonzero `m_exccode` is treated as an exception.
- **Entry (sync exception or interrupt).**
  - Asserts `flush`, `pc_sel`, `exl_set`, and `next_pc` = HANDLER_ADDR.
  - If state == IDLE, also asserts `cp0_we_exc` with:
    - `cp0_code` = `m_exccode` (0 for an interrupt);
    - `cp0_bd` = `m_bd`;
    - `cp0_epc` = {`m_pc`[31:2], 2'b00}, minus 4 when `m_bd` = 1;
    - `cp0_hwint` = `hw_q`.
  - If state == HANDLER (nested sync exception), `cp0_we_exc` = 0, so the original EPC/Cause is preserved.
  - `exc_count` increments by 1 and saturates at all-ones.
  - Next state: HANDLER.
- **Return.** Asserts `flush`, `pc_sel`, `exl_clr`, and `next_pc` = `epc_in`; next state IDLE. `eret` in IDLE behaves identically.
- **FSM** (2 states, reset IDLE):
  - IDLE → HANDLER on entry.
  - HANDLER → IDLE on return, or when `sr_exl` is sampled 0 (software cleared EXL by `mtc0`).
  - HANDLER → HANDLER on a nested entry.
- **Bubbles.** With `m_valid` = 0, no action is taken. A pending interrupt waits until a real instruction reaches M, so EPC is always precise.
- **Idle outputs.** When no decision fires, all strobes are 0, `next_pc` = 0 and the `cp0_*` outputs are 0.

## Timing
- **Reset.** All outputs are 0 after reset: `flush`, `pc_sel`, `next_pc`, `cp0_*`, `exl_set`, `exl_clr`, `in_handler` and `exc_count`.
- **Strobe width.** Strobes are combinational from the M-stage inputs and `hw_q`, and are valid for the one cycle the decision holds. `exl_set` and `exl_clr` are never both 1.
- **State and counter.** These update at the posedge closing the decision cycle, so `in_handler` rises 1 cycle after entry.
- **Interrupt latency.** `hwint` rising at edge k produces an entry in cycle k+1 at the earliest (needs `m_valid`). `hwint` dropping before it is sampled produces no entry.
- **Back-to-back.** Return in cycle t followed by `irq` in cycle t+1 is legal. `irq` is evaluated against the state after the return, so entry occurs once `sr_exl` reads 0 and M is valid.
- **Simultaneous events.** A sync exception together with `irq` records the sync code, with `cp0_hwint` still capturing `hw_q`.
- **Reset mid-handler.** State returns to IDLE and the counter clears; no strobes are asserted in the reset cycle.

## Test plan
- **Sync exception.** `m_valid` = 1, `m_exccode` = 12, `m_pc` = 0x3010, `m_bd` = 0 → one cycle with `flush`, `pc_sel`, `exl_set`, `cp0_we_exc`; `cp0_code` = 12, `cp0_epc` = 0x3010, `next_pc` = 0x4180; `in_handler` = 1 next cycle; `exc_count` = 1.
- **Delay-slot exception.** `m_bd` = 1, `m_pc` = 0x3024, `m_exccode` = 4 → `cp0_epc` = 0x3020, `cp0_bd` = 1.
- **Interrupt through bubbles.** `hwint` = 6'b000100, `sr_im` = 6'b000100, `sr_ie` = 1, `sr_exl` = 0, `m_valid` low for 3 cycles then high → no action for 3 cycles, then entry with `cp0_code` = 0 and `cp0_hwint` = 6'b000100.
- **Nested exception.** In HANDLER, `m_exccode` = 10 → `flush`/`pc_sel` to 0x4180 with `cp0_we_exc` = 0; `exc_count` increments.
- **Return.** `m_eret` with `epc_in` = 0x3020 → `flush`, `pc_sel`, `exl_clr`, `next_pc` = 0x3020; state IDLE next cycle. With `sr_im` = 0, a held `hwint` causes no entry.
- **Reset and saturation.** Assert `reset` in HANDLER → `in_handler` = 0 and `exc_count` = 0 next cycle. With `CNT_W` = 2, five entries → `exc_count` = 3.
